// File: rtl/rpg_multi.sv
// Parametrised LBIST random pattern generator: emits a run of N patterns from a
// Fibonacci LFSR or a binary counter, with seeding, continuation and stall support.
module rpg_multi #(
   parameter int                 WIDTH = 8,
   parameter logic [WIDTH-1:0]   POLY  = 8'hB8,
   parameter int                 CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic               cont,
   input  logic [WIDTH-1:0]   seed,
   input  logic [CNT_W-1:0]   num_pat,
   input  logic               hold,
   output logic [WIDTH-1:0]   register,
   output logic               valid,
   output logic [CNT_W-1:0]   pat_idx,
   output logic               busy,
   output logic               END
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   pat_r, pat_s;
   logic [WIDTH-1:0]   load_s;
   logic [CNT_W-1:0]   idx_r, idx_s;
   logic [CNT_W-1:0]   npat_r, npat_s;
   logic               mode_r, mode_s;

   // Successor pattern: counter increment (cnt_mode=1) or Fibonacci LFSR shift.
   function automatic logic [WIDTH-1:0] next_pat(input logic [WIDTH-1:0] cur,
                                                  input logic             cnt_mode);
      if (cnt_mode) begin
         next_pat = cur + PAT_ONE;
      end else begin
         next_pat = {cur[WIDTH-2:0], ^(cur & POLY)};
      end
   endfunction

   // Next-state, pattern and index computation for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_s = state_r;
      pat_s   = pat_r;
      idx_s   = idx_r;
      npat_s  = npat_r;
      mode_s  = mode_r;
      load_s  = PAT_ZERO;
      case (state_r)
         IDLE: begin
            if (start && (num_pat != IDX_ZERO)) begin
               state_s = RUN;
               mode_s  = mode;
               npat_s  = num_pat;
               idx_s   = IDX_ZERO;
               // Continuing steps once so the previous run's last pattern is not repeated.
               if (cont) begin
                  load_s = next_pat(pat_r, mode);
               end else begin
                  load_s = seed;
               end
               // An all-zero LFSR state would lock up; the counter may start at zero.
               if (!mode && (load_s == PAT_ZERO)) begin
                  pat_s = PAT_ONE;
               end else begin
                  pat_s = load_s;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (hold) begin
               state_s = RUN;
            end else if (idx_r == (npat_r - IDX_ONE)) begin
               state_s = DONE;
            end else begin
               pat_s = next_pat(pat_r, mode_r);
               idx_s = idx_r + IDX_ONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, pattern, index and run-parameter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         pat_r   <= PAT_ZERO;
         idx_r   <= IDX_ZERO;
         npat_r  <= IDX_ZERO;
         mode_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pat_r   <= pat_s;
         idx_r   <= idx_s;
         npat_r  <= npat_s;
         mode_r  <= mode_s;
      end
   end

   assign register = pat_r;
   assign pat_idx  = idx_r;
   assign valid    = (state_r == RUN) & ~hold;
   assign busy     = (state_r != IDLE);
   assign END      = (state_r == DONE);

endmodule
